// File: rtl/alu_muldiv_seq.sv
// Multi-cycle unsigned MUL/MULHU/DIVU/REMU sequencer.
// Has no adder of its own: it borrows the core's shared ALU for one
// shift-add (multiply) or shift-subtract (restoring divide) step per cycle.
module alu_muldiv_seq #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             alu_req,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_ctrl,
    input  logic [WIDTH-1:0] alu_out
);

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;

    state_t           state_q, state_d;
    logic [1:0]       op_q, op_d;
    // Multiplicand for multiply, divisor for divide.
    logic [WIDTH-1:0] opnd_q, opnd_d;
    // hi doubles as the remainder and lo as the quotient during a divide.
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] result_q, result_d;

    logic [WIDTH-1:0] shifted;
    logic             ovf;
    logic             carry;

    assign result = result_q;

    // Next-state, datapath step and shared-ALU request.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        opnd_d   = opnd_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        busy     = 1'b0;
        done     = 1'b0;
        alu_req  = 1'b0;
        alu_a    = '0;
        alu_b    = '0;
        alu_ctrl = ALU_ADD;

        shifted = {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};
        ovf     = hi_q[WIDTH-1];
        carry   = (alu_out < hi_q);

        case (state_q)
            IDLE: begin
                if (start) begin
                    op_d   = op;
                    opnd_d = op[1] ? src_b : src_a;
                    cnt_d  = '0;
                    if (op[1] && (src_b == '0)) begin
                        // Divide by zero: quotient all ones, remainder = dividend.
                        hi_d     = src_a;
                        lo_d     = '1;
                        result_d = op[0] ? src_a : '1;
                        state_d  = FIN;
                    end else begin
                        hi_d    = '0;
                        lo_d    = op[1] ? src_a : src_b;
                        state_d = RUN;
                    end
                end
            end

            RUN: begin
                busy    = 1'b1;
                alu_req = 1'b1;
                alu_b   = opnd_q;
                if (op_q[1]) begin
                    alu_a    = shifted;
                    alu_ctrl = ALU_SUB;
                    if (ovf || (shifted >= opnd_q)) begin
                        hi_d = alu_out;
                        lo_d = {lo_q[WIDTH-2:0], 1'b1};
                    end else begin
                        hi_d = shifted;
                        lo_d = {lo_q[WIDTH-2:0], 1'b0};
                    end
                end else begin
                    alu_a    = hi_q;
                    alu_ctrl = ALU_ADD;
                    if (lo_q[0]) begin
                        hi_d = {carry, alu_out[WIDTH-1:1]};
                        lo_d = {alu_out[0], lo_q[WIDTH-1:1]};
                    end else begin
                        hi_d = {1'b0, hi_q[WIDTH-1:1]};
                        lo_d = {hi_q[0], lo_q[WIDTH-1:1]};
                    end
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    // Result must be valid in the done cycle, so it is taken
                    // from the final step's next values.
                    result_d = op_q[0] ? hi_d : lo_d;
                    state_d  = FIN;
                end
            end

            FIN: begin
                done    = 1'b1;
                state_d = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            op_q     <= '0;
            opnd_q   <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            opnd_q   <= opnd_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Self-checking bench for alu_muldiv_seq with a scoreboard of expected results.
module tb_alu_muldiv_seq;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] src_a, src_b;
    logic         busy, done, alu_req;
    logic [W-1:0] result, alu_a, alu_b, alu_out;
    logic [3:0]   alu_ctrl;

    typedef struct {
        logic [W-1:0] res;
        int           lat;
        logic [3:0]   ctrl;
    } exp_t;

    exp_t sb[$];
    int   n_pass  = 0;
    int   n_total = 0;

    always #5 clk = ~clk;

    // Shared core ALU, combinational.
    assign alu_out = (alu_ctrl == 4'b0001) ? (alu_a - alu_b) : (alu_a + alu_b);

    alu_muldiv_seq #(.WIDTH(W), .CNT_W(6)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .op       (op),
        .src_a    (src_a),
        .src_b    (src_b),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .alu_req  (alu_req),
        .alu_a    (alu_a),
        .alu_b    (alu_b),
        .alu_ctrl (alu_ctrl),
        .alu_out  (alu_out)
    );

    task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [W-1:0] model(input logic [1:0] o, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
        logic [2*W-1:0] p;
        p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        case (o)
            2'b00:   return p[W-1:0];
            2'b01:   return p[2*W-1:W];
            2'b10:   return (b == '0) ? '1 : a / b;
            default: return (b == '0) ? a : a % b;
        endcase
    endfunction

    // Issue one operation and follow it to done; inject_k > 0 drives a
    // stray start during that cycle after the accepting edge.
    task automatic run_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                          input int inject_k, input string tag);
        exp_t e;
        exp_t got_e;
        bit   seen;
        bit   run_ok;
        e.res  = model(o, a, b);
        e.lat  = (o[1] && b == '0) ? 1 : W + 1;
        e.ctrl = o[1] ? 4'b0001 : 4'b0000;
        sb.push_back(e);
        seen   = 1'b0;
        run_ok = 1'b1;
        @(negedge clk);
        start = 1'b1; op = o; src_a = a; src_b = b;
        @(negedge clk);
        start = 1'b0; op = 2'($urandom); src_a = $urandom; src_b = $urandom;
        for (int k = 1; k <= 40; k++) begin
            if (k > 1) @(negedge clk);
            if (k == inject_k) begin
                start = 1'b1; op = 2'b10; src_a = 32'd1000; src_b = 32'd3;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                seen = 1'b1;
                if (sb.size() == 0) begin
                    check_eq({tag, " sb-empty"}, 32'd0, 32'd1);
                end else begin
                    got_e = sb.pop_front();
                    check_eq({tag, " result"}, result, got_e.res);
                    check_eq({tag, " latency"}, 32'(k), 32'(got_e.lat));
                end
                check_eq({tag, " done-outs"},
                         {alu_a | alu_b} | {26'd0, busy, alu_req, alu_ctrl}, 32'd0);
                break;
            end else if (!(busy && alu_req && alu_ctrl == e.ctrl)) begin
                run_ok = 1'b0;
            end
        end
        if (!seen) check_eq({tag, " timeout"}, 32'd0, 32'd1);
        check_eq({tag, " run-outs"}, 32'(run_ok), 32'd1);
        @(negedge clk);
        start = 1'b0;
        check_eq({tag, " after-done"}, {30'd0, busy, done}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit done_seen;
        rst_n = 1'b0; start = 1'b0; op = '0; src_a = '0; src_b = '0;
        repeat (2) @(negedge clk);
        check_eq("reset outs", {28'd0, busy, done, alu_req, 1'b0}, 32'd0);
        check_eq("reset result", result, 32'd0);
        check_eq("reset alu", alu_a | alu_b | {28'd0, alu_ctrl}, 32'd0);
        rst_n = 1'b1;

        run_op(2'b00, 32'd7, 32'd6, 0, "mul 7x6");
        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "mulhu ffx ff");
        run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "mul ffx ff");
        run_op(2'b10, 32'd100, 32'd7, 0, "divu 100/7");
        run_op(2'b11, 32'd100, 32'd7, 0, "remu 100/7");
        run_op(2'b10, 32'hFFFF_FFFF, 32'd1, 0, "divu ff/1");
        run_op(2'b10, 32'd123, 32'd0, 0, "divu 123/0");
        run_op(2'b11, 32'd123, 32'd0, 0, "remu 123/0");
        run_op(2'b10, 32'hFFFF_FFFF, 32'h8000_0001, 0, "divu ovf");
        run_op(2'b11, 32'hFFFF_FFFF, 32'h8000_0001, 0, "remu ovf");

        run_op(2'b00, 32'd3, 32'd5, 10, "mul 3x5 ign");
        repeat (6) @(negedge clk);
        check_eq("result held", result, 32'd15);
        run_op(2'b11, 32'd1000, 32'd3, 33, "remu fin-ign");

        for (int i = 0; i < 8; i++) begin
            logic [1:0]   ro;
            logic [W-1:0] ra, rb;
            ro = 2'(i);
            ra = $urandom;
            rb = (i >= 4) ? 32'($urandom_range(1, 70000)) : $urandom;
            run_op(ro, ra, rb, 0, "random");
        end

        // Reset in the middle of a multiply.
        @(negedge clk);
        start = 1'b1; op = 2'b00; src_a = 32'h1234; src_b = 32'd5;
        @(negedge clk);
        start = 1'b0;
        for (int k = 2; k <= 12; k++) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check_eq("midrst busy", {31'd0, busy}, 32'd0);
        check_eq("midrst alu_req", {31'd0, alu_req}, 32'd0);
        check_eq("midrst result", result, 32'd0);
        rst_n = 1'b1;
        done_seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done || busy) done_seen = 1'b1;
        end
        check_eq("midrst no done", {31'd0, done_seen}, 32'd0);
        run_op(2'b10, 32'd9, 32'd2, 0, "divu 9/2");

        check_eq("sb drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
